serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor computing diff = a - b, processing one bit per clock, LSB first. It uses a single full-subtractor cell and a borrow flip-flop. This is the subtract-direction counterpart to the team's adder blocks. It sits behind a start/done handshake, so a controller can issue operations without a wide parallel subtract path.

Parameters:
WIDTH, 8, operand and result width in bits (must be >= 2)

Ports:
clk    input   1      system clock, rising-edge active
rst    input   1      asynchronous, active-high reset
start  input   1      request pulse; sampled only when busy=0
a      input   WIDTH  minuend; captured on the accepted-start edge
b      input   WIDTH  subtrahend; captured on the accepted-start edge
busy   output  1      high while bits are being processed
done   output  1      single-cycle pulse; result valid
diff   output  WIDTH  difference a - b mod 2^WIDTH; valid when done=1, held until next accepted start
bout   output  1      final borrow out (1 when a < b unsigned); same validity as diff

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, diff=0, bout=0, borrow reg=0, bit counter=0. Outputs reach these values immediately on rst assertion, independent of clk.
- States: IDLE, SHIFT, DONE. Two-bit encoding: IDLE=0, SHIFT=1, DONE=2. The unused code returns to IDLE.
- Start acceptance: start=1 at a rising edge while in IDLE or DONE. On that edge:
  - a, b load into internal shift registers.
  - borrow clears to 0 and counter clears to 0.
  - state moves to SHIFT, so busy=1 from the next cycle.
- start while busy=1 is ignored; operands are not recaptured.
- SHIFT, each edge:
  - d = a0 ^ b0 ^ bor
  - bor_next = (~a0 & b0) | (~(a0 ^ b0) & bor)
  - a and b shift right by one; d enters diff at the MSB while diff shifts right.
  - counter increments.
  - On the edge where counter == WIDTH-1 (the WIDTH-th shift): state moves to DONE, and bout is loaded with bor_next.
- Timing: if start is accepted at edge E0, bits are processed at edges E1..E_WIDTH. done=1 and busy=0 during the cycle after E_WIDTH. Latency from start edge to done is WIDTH+1 edges.
- DONE lasts exactly one cycle:
  - With start=1 at that edge, go to SHIFT (back-to-back operation; done pulses are separated by WIDTH+1 cycles).
  - Otherwise go to IDLE.
  - diff and bout hold their values in IDLE.
- diff is not meaningful while busy=1, because it shifts every cycle.
- busy and done are registered (decoded from state) and are never high together.
- Reset mid-operation aborts immediately, with no done pulse. After rst deasserts, the first edge with start=1 starts cleanly.
- Arithmetic: the result is modulo 2^WIDTH. bout is the unsigned borrow. The signed result is diff interpreted as two's complement. No overflow flag.

Decomposition:
- Package serial_sub_pkg:
  - state encoding constants ST_IDLE, ST_SHIFT, ST_DONE
  - default WIDTH constant
- One natural sub-module: full_subtractor. It is combinational, with inputs x, y, bin and outputs d, bout, and is instantiated once for the bit slice.
- Counter width is clog2(WIDTH).

Test Plan:
- Basic: WIDTH=8, a=0x05, b=0x03, start for 1 cycle -> busy for 8 cycles, then done=1 for 1 cycle at edge 9; diff=0x02, bout=0; both held in IDLE.
- Borrow chain: a=0x03, b=0x05 -> diff=0xFE, bout=1. Also a=0x00, b=0x01 -> diff=0xFF, bout=1 (borrow ripples through all 8 bits).
- Equal and extreme operands: a=b=0xA5 -> diff=0x00, bout=0. a=0xFF, b=0x00 -> diff=0xFF, bout=0. a=0x80, b=0x7F -> diff=0x01, bout=0.
- Start while busy: start a=0x10, b=0x01, then pulse start with a=0x55, b=0x11 at cycle 4 -> the second start is ignored; diff=0x0F, bout=0; exactly one done pulse.
- Back-to-back: hold start=1 with new operands (a=0x20, b=0x30) during the DONE cycle -> busy=1 the next cycle, second done exactly 9 edges later with diff=0xF0, bout=1.
- Reset mid-op: assert rst asynchronously (between edges) at cycle 5 of an operation -> busy, done, diff and bout go to 0 immediately, no done pulse. A new start after release gives the correct result (0x09 - 0x04 -> 0x05, bout=0).

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Purpose : shared state encoding and default width for the bit-serial subtractor.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // Code 2'd3 is unused; the FSM steers it back to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Purpose : one-bit full subtractor, d = x - y - bin with borrow out.
// Latency : combinational.
// Backpressure: none.
// Ports   : x (minuend bit), y (subtrahend bit), bin (borrow in),
//           d (difference bit), bout (borrow out).
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial two's-complement subtractor, diff = a - b, LSB first.
// Latency : WIDTH+1 edges from the accepted start edge to the done pulse.
// Backpressure: start is ignored while busy; accepted in IDLE or the DONE cycle.
// Ports   : clk, rst (async, active high), start, a, b  -> busy, done, diff, bout.
//           diff/bout are valid with done and held until the next accepted start.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             bor;
   logic [CW-1:0]    cnt;
   logic             bit_d;
   logic             bit_b;

   full_subtractor u_fs (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (bor),
      .d    (bit_d),
      .bout (bit_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // busy/done decode straight from the state register, so they are glitch-free
   // and mutually exclusive.
   always_comb begin
      state_nxt = ST_IDLE;
      accept    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            busy      = 1'b1;
            state_nxt = (cnt == LAST) ? ST_DONE : ST_SHIFT;
         end
         ST_DONE: begin
            done = 1'b1;
            // start during the done cycle chains straight into the next op.
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr <= '0;
         b_sr <= '0;
         bor  <= 1'b0;
         cnt  <= '0;
         diff <= '0;
         bout <= 1'b0;
      end else if (accept) begin
         a_sr <= a;
         b_sr <= b;
         bor  <= 1'b0;
         cnt  <= '0;
      end else if (state == ST_SHIFT) begin
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         // After WIDTH shifts the first (LSB) difference bit lands at diff[0].
         diff <= {bit_d, diff[WIDTH-1:1]};
         bor  <= bit_b;
         cnt  <= cnt + 1'b1;
         if (cnt == LAST) begin
            bout <= bit_b;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Timeline view: an op accepted at edge index acc keeps the unit busy for
   // the W cycles following that edge, then done for one cycle, at which point
   // the result a-b (mod 2^W) and the unsigned borrow a<b become visible.
   int           edge_n = 0;
   int           acc = -1000000;
   logic [W-1:0] pend_d = '0;
   logic         pend_b = 1'b0;
   logic [W-1:0] exp_diff = '0;
   logic         exp_bout = 1'b0;

   function automatic bit in_busy(input int ph);
      return (ph >= 0) && (ph < W);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         acc      <= -1000000;
         exp_diff <= '0;
         exp_bout <= 1'b0;
      end else begin
         edge_n <= edge_n + 1;
         if (start && !in_busy(edge_n - acc)) begin
            acc    <= edge_n + 1;
            pend_d <= a - b;
            pend_b <= (a < b);
         end
         if (edge_n + 1 - acc == W) begin
            exp_diff <= pend_d;
            exp_bout <= pend_b;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin : cmp
      int  ph;
      bit  eb;
      bit  ed;
      if (chk_en) begin
         ph = edge_n - acc;
         eb = !rst && in_busy(ph);
         ed = !rst && (ph == W);
         chk("busy", 32'(busy), 32'(eb));
         chk("done", 32'(done), 32'(ed));
         if (!eb) begin
            chk("diff", 32'(diff), 32'(exp_diff));
            chk("bout", 32'(bout), 32'(exp_bout));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
      @(posedge clk);
      #3;
      start = s;
      a     = av;
      b     = bv;
   endtask

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] ed, input logic eb);
      int n;
      drive(1'b1, av, bv);
      n = 0;
      do begin
         drive(1'b0, '0, '0);
         @(negedge clk);
         n++;
      end while (!done && n < 20);
      chk("done_seen", 32'(done), 32'd1);
      chk("latency", 32'(n), 32'(W + 1));
      chk("lit_diff", 32'(diff), 32'(ed));
      chk("lit_bout", 32'(bout), 32'(eb));
      chk("model_diff", 32'(exp_diff), 32'(ed));
      chk("model_bout", 32'(exp_bout), 32'(eb));
      repeat (3) drive(1'b0, '0, '0);   // idle: held values checked by cmp
   endtask

   initial begin
      int ndone;
      int d1;
      int d2;
      logic [W-1:0] d_at2;
      logic         b_at2;

      #1 rst = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Directed cases
      run_op(8'h05, 8'h03, 8'h02, 1'b0);
      run_op(8'h03, 8'h05, 8'hFE, 1'b1);
      run_op(8'h00, 8'h01, 8'hFF, 1'b1);
      run_op(8'hA5, 8'hA5, 8'h00, 1'b0);
      run_op(8'hFF, 8'h00, 8'hFF, 1'b0);
      run_op(8'h80, 8'h7F, 8'h01, 1'b0);

      // start while busy is ignored
      drive(1'b1, 8'h10, 8'h01);
      ndone = 0;
      for (int i = 1; i <= 25; i++) begin
         if (i == 4) drive(1'b1, 8'h55, 8'h11);
         else        drive(1'b0, '0, '0);
         @(negedge clk);
         if (done) begin
            ndone++;
            chk("busy_ign_diff", 32'(diff), 32'h0F);
            chk("busy_ign_bout", 32'(bout), 32'd0);
         end
      end
      chk("busy_ign_ndone", 32'(ndone), 32'd1);

      // back-to-back: start held during the done cycle
      drive(1'b1, 8'h40, 8'h01);
      d1 = 0; d2 = 0; d_at2 = '0; b_at2 = 1'b0;
      for (int i = 1; i <= 2 * W + 4; i++) begin
         if (i == W + 1) drive(1'b1, 8'h20, 8'h30);
         else            drive(1'b0, '0, '0);
         @(negedge clk);
         if (done && d1 == 0) d1 = i;
         else if (done && d2 == 0) begin
            d2 = i; d_at2 = diff; b_at2 = bout;
         end
         if (i == W + 2) chk("b2b_busy", 32'(busy), 32'd1);
      end
      chk("b2b_first", 32'(d1), 32'(W + 1));
      chk("b2b_gap", 32'(d2 - d1), 32'(W + 1));
      chk("b2b_diff", 32'(d_at2), 32'hF0);
      chk("b2b_bout", 32'(b_at2), 32'd1);

      // reset mid-operation, asserted between edges
      drive(1'b1, 8'h33, 8'h11);
      repeat (4) drive(1'b0, '0, '0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_diff", 32'(diff), 32'd0);
      chk("mid_rst_bout", 32'(bout), 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      repeat (12) drive(1'b0, '0, '0);   // cmp flags any stray done
      run_op(8'h09, 8'h04, 8'h05, 1'b0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            @(posedge clk);
            #3 rst = 1'b1;
            @(posedge clk);
            #3 rst = 1'b0;
         end
         drive(1'($urandom_range(0, 2) == 0), W'($urandom), W'($urandom));
      end
      repeat (W + 4) drive(1'b0, '0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
